// File: rtl/fb_loader_if.sv
// Byte-stream input and framebuffer write-port bundle for fb_loader.
interface fb_loader_if #(
    parameter int unsigned XW = 7,
    parameter int unsigned YW = 7
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [7:0]    wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          busy;
    logic          pkt_done;
    logic          err;

    modport master (
        output in_data, in_valid, wr_ready,
        input  in_ready, wr_x, wr_y, wr_data, wr_valid, busy, pkt_done, err
    );

    modport slave (
        input  in_data, in_valid, wr_ready,
        output in_ready, wr_x, wr_y, wr_data, wr_valid, busy, pkt_done, err
    );
endinterface

// File: rtl/fb_loader.sv
// Packet parser that turns a byte stream into framebuffer pixel writes.
// Optional trailing XOR checksum is enabled by defining FB_LOADER_CHECKSUM_EN.
module fb_loader #(
    parameter int unsigned W    = 128,
    parameter int unsigned H    = 128,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input logic      clk,
    input logic      rst_n,
    fb_loader_if.slave bus
);
    localparam int unsigned XW = $clog2(W);
    localparam int unsigned YW = $clog2(H);

    typedef enum logic [2:0] {StIdle, StX, StY, StCnt, StData, StChk} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, wx_q, wx_d;
    logic [YW-1:0] y_q, y_d, wy_q, wy_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wvalid_q, wvalid_d;
    logic          done_q, done_d;
    logic          in_ready;
    logic          accept;
`ifdef FB_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
    logic          err_q, err_d;
`endif

    // The output register only blocks input while it holds an unconsumed write.
    always_comb begin
        in_ready = 1'b1;
        if (state_q == StData || state_q == StChk) in_ready = !wvalid_q || bus.wr_ready;
    end
    assign accept = bus.in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        wx_d     = wx_q;
        wy_d     = wy_q;
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q && !bus.wr_ready;
        done_d   = 1'b0;
`ifdef FB_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        err_d    = err_q;
`endif
        if (accept) begin
`ifdef FB_LOADER_CHECKSUM_EN
            if (state_q != StIdle && state_q != StChk) csum_d = csum_q ^ bus.in_data;
`endif
            unique case (state_q)
                StIdle: begin
                    if (bus.in_data == SYNC) begin
                        state_d = StX;
`ifdef FB_LOADER_CHECKSUM_EN
                        csum_d  = 8'h00;
                        err_d   = 1'b0;
`endif
                    end
                end
                StX: begin
                    x_d     = bus.in_data[XW-1:0];
                    state_d = StY;
                end
                StY: begin
                    y_d     = bus.in_data[YW-1:0];
                    state_d = StCnt;
                end
                StCnt: begin
                    cnt_d   = (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
                    state_d = StData;
                end
                StData: begin
                    wdata_d  = bus.in_data;
                    wx_d     = x_q;
                    wy_d     = y_q;
                    wvalid_d = 1'b1;
                    // Power-of-two dimensions make both wraps natural overflow.
                    x_d      = x_q + XW'(1);
                    if (x_q == XW'(W - 1)) y_d = y_q + YW'(1);
                    cnt_d    = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
`ifdef FB_LOADER_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end
                end
`ifdef FB_LOADER_CHECKSUM_EN
                StChk: begin
                    if (bus.in_data != csum_q) err_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            wx_q     <= '0;
            wy_q     <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef FB_LOADER_CHECKSUM_EN
            csum_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            done_q   <= done_d;
`ifdef FB_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_x     = wx_q;
    assign bus.wr_y     = wy_q;
    assign bus.wr_data  = wdata_q;
    assign bus.wr_valid = wvalid_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.pkt_done = done_q;
`ifdef FB_LOADER_CHECKSUM_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_fb_loader.sv
// Directed bench for fb_loader; writes are logged on the falling edge and checked against
// hand-computed coordinates. Checksum steps run when FB_LOADER_CHECKSUM_EN is defined.
module tb_fb_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_loader_if #(.XW(7), .YW(7)) bus ();

    fb_loader #(.W(128), .H(128), .SYNC(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int viol = 0;
    bit rnd_on = 1'b0;
    int lx[$], ly[$], ld[$], lc[$];
    logic [7:0] pkt_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            bus.wr_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_valid && bus.wr_ready) begin
                lx.push_back(int'(bus.wr_x));
                ly.push_back(int'(bus.wr_y));
                ld.push_back(int'(bus.wr_data));
                lc.push_back(cyc);
            end
            if (bus.pkt_done) done_cnt++;
            if (!bus.in_ready && !(bus.wr_valid && !bus.wr_ready)) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Sends pkt_q; appends the XOR of everything after SYNC in the checksum build.
    task automatic send_pkt();
        logic [7:0] cs = 8'h00;
        foreach (pkt_q[i]) begin
            send(pkt_q[i]);
            if (i > 0) cs = cs ^ pkt_q[i];
        end
`ifdef FB_LOADER_CHECKSUM_EN
        send(cs);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        lx.delete(); ly.delete(); ld.delete(); lc.delete();
        done_cnt = 0;
    endtask

    task automatic check_wr(input string tag, input int i, input int x, input int y, input int d);
        if (i < lx.size()) begin
            check({tag, "_x"}, lx[i], x);
            check({tag, "_y"}, ly[i], y);
            check({tag, "_d"}, ld[i], d);
        end else begin
            check({tag, "_present"}, lx.size(), i + 1);
        end
    endtask

    initial begin
        int bad;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_wr_xyd", {bus.wr_x, bus.wr_y, bus.wr_data}, 0);
        check("rst_pkt_done", bus.pkt_done, 0);
        check("rst_err", bus.err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Junk in IDLE is dropped
        send(8'h00);
        send(8'h12);
        idle(2);
        check("junk_busy", bus.busy, 0);
        check("junk_writes", lx.size(), 0);

        clear_log();
        pkt_q = '{8'hA5, 8'h05, 8'h03, 8'h02, 8'h11, 8'h22};
        send_pkt();
        idle(3);
        check("p1_count", lx.size(), 2);
        check_wr("p1_w0", 0, 5, 3, 8'h11);
        check_wr("p1_w1", 1, 6, 3, 8'h22);
        if (lc.size() == 2) check("p1_back_to_back", lc[1] - lc[0], 1);
        check("p1_done", done_cnt, 1);
        check("p1_busy", bus.busy, 0);

        clear_log();
        pkt_q = '{8'hA5, 8'h7E, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03};
        send_pkt();
        pkt_q = '{8'hA5, 8'h7F, 8'h7F, 8'h02, 8'hAA, 8'hBB};
        send_pkt();
        idle(3);
        check("wrap_count", lx.size(), 5);
        check_wr("wrap_w0", 0, 126, 16, 8'h01);
        check_wr("wrap_w1", 1, 127, 16, 8'h02);
        check_wr("wrap_w2", 2, 0, 17, 8'h03);
        check_wr("wrap_w3", 3, 127, 127, 8'hAA);
        check_wr("wrap_w4", 4, 0, 0, 8'hBB);
        check("wrap_done", done_cnt, 2);

        // N=0 means 256 pixels, under random backpressure
        clear_log();
        viol = 0;
        rnd_on = 1'b1;
        pkt_q = '{8'hA5, 8'h40, 8'h05, 8'h00};
        for (int i = 0; i < 256; i++) pkt_q.push_back(8'(i));
        send_pkt();
        rnd_on = 1'b0;
        idle(1);
        bus.wr_ready = 1'b1;
        idle(3);
        check("n256_count", lx.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < lx.size(); i++) begin
            if (lx[i] != (64 + i) % 128 || ly[i] != 5 + (64 + i) / 128 || ld[i] != i) bad++;
        end
        check("n256_order", bad, 0);
        check("n256_in_ready", viol, 0);
        check("n256_done", done_cnt, 1);

        // Reset mid-packet after the second pixel
        clear_log();
        send(8'hA5); send(8'h10); send(8'h10); send(8'h04);
        send(8'h01); send(8'h02);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_valid", bus.wr_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        clear_log();
        send(8'h03);
        send(8'h04);
        idle(3);
        check("mid_rst_no_writes", lx.size(), 0);
        check("mid_rst_idle", bus.busy, 0);

`ifdef FB_LOADER_CHECKSUM_EN
        clear_log();
        send(8'hA5); send(8'h01); send(8'h02); send(8'h01); send(8'h33); send(8'h31);
        idle(2);
        check("cs_good_err", bus.err, 0);
        check("cs_good_done", done_cnt, 1);
        check_wr("cs_good_w0", 0, 1, 2, 8'h33);
        clear_log();
        send(8'hA5); send(8'h01); send(8'h02); send(8'h01); send(8'h33); send(8'h00);
        idle(3);
        check("cs_bad_err", bus.err, 1);
        check("cs_bad_done", done_cnt, 1);
        check("cs_bad_written", lx.size(), 1);
        send(8'hA5);
        @(negedge clk);
        check("cs_err_cleared", bus.err, 0);
`else
        clear_log();
        send(8'hA5); send(8'h01); send(8'h02); send(8'h01); send(8'h33);
        idle(2);
        check("nocs_done", done_cnt, 1);
        check("nocs_busy", bus.busy, 0);
        check("nocs_err", bus.err, 0);
        check_wr("nocs_w0", 0, 1, 2, 8'h33);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fb_loader.md
# fb_loader

Packet-driven framebuffer writer sitting directly upstream of the VGA scan-out stage. Consumes a byte stream (e.g. from the UART receiver) over a valid/ready handshake, parses small rectangular-run packets, and issues one framebuffer write per pixel byte into the 128×128×8-bit image memory the scan-out reads. Handles row wrap-around and write-port backpressure so the display memory can be rewritten at runtime instead of only via the initial hex image.

## Interface

Parameters:
- `W`, 128: framebuffer width in pixels (power of two).
- `H`, 128: framebuffer height in pixels (power of two).
- `SYNC`, 8'hA5: packet header byte.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_data`  in  8  incoming byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted when `in_valid & in_ready` at a rising edge.
- `wr_x`  out  log2(W)  framebuffer column.
- `wr_y`  out  log2(H)  framebuffer row.
- `wr_data`  out  8  pixel value (bits [5:0] = RRGGBB, [7:6] passed through).
- `wr_valid`  out  1  write request.
- `wr_ready`  in  1  write consumed when `wr_valid & wr_ready`.
- `busy`  out  1  high in any state other than IDLE.
- `pkt_done`  out  1  one-cycle pulse at end of packet.
- `err`  out  1  sticky error flag (checksum build only; tied 0 otherwise).

## Operation

- Packet: `SYNC`, X, Y, N, then N pixel bytes (N = 0 means 256), then a checksum byte if enabled.
- States: IDLE → X → Y → CNT → DATA → (CHK) → IDLE. Each transition occurs on an accepted byte.
- IDLE: bytes ≠ `SYNC` are accepted and dropped silently. A `SYNC` byte moves to X.
- X/Y: load the column/row pointer from the low log2(W)/log2(H) bits; upper bits are ignored.
- CNT: load the 8-bit remaining count; 0 is treated as 256.
- DATA: each accepted byte loads `wr_data` with the byte, loads `wr_x`/`wr_y` with the current pointer, and sets `wr_valid`. The pointer then advances: x+1; when x = W−1, x→0 and y+1; when y = H−1 as well, y→0 (full-frame wrap). The count decrements; acceptance of the last byte exits DATA.
- Backpressure: one-entry output register. In DATA/CHK, `in_ready = !wr_valid | wr_ready`. In IDLE/X/Y/CNT, `in_ready = 1`. `wr_valid` clears when the write is consumed and no new byte is accepted in the same cycle. Simultaneous consume and accept reloads the register with no bubble.
- `busy` stays high until the FSM returns to IDLE. It does not wait for the final `wr_valid` to drain.
- Reset (any state, mid-packet included): FSM → IDLE, pointers/count → 0, `wr_valid` = 0, `pkt_done` = 0, `err` = 0, `in_ready` = 1, `wr_x`/`wr_y`/`wr_data` = 0. Any pending write is discarded.

## Timing

- Byte accepted at edge k in DATA → `wr_valid`/`wr_*` visible after edge k; earliest consumption at edge k+1.
- Sustained throughput is 1 pixel/clock when `wr_ready` is held high.
- `pkt_done` is high for exactly the cycle following acceptance of the last packet byte (last pixel, or checksum byte if enabled).
- A new `SYNC` byte can be accepted the cycle after the packet ends; there are no dead cycles.

## Configuration

- `FB_LOADER_CHECKSUM_EN`, defined: adds a CHK state after DATA. A running XOR covers X, Y, N and all pixel bytes and is cleared on `SYNC`. At CHK, a mismatch sets `err`. Pixels are already written and are not rolled back. `err` clears on the next accepted `SYNC` or on reset. `pkt_done` fires on the checksum byte.
- `FB_LOADER_CHECKSUM_EN`, undefined: there is no CHK state. `err` is constant 0, and packets end on the last pixel.

## Test plan

- Reset, then bytes 0x00, 0x12 → both accepted and dropped; `busy` = 0; no `wr_valid`.
- Packet A5 05 03 02 11 22 with `wr_ready` = 1 → writes (5,3,0x11), (6,3,0x22) on consecutive cycles; one `pkt_done` pulse.
- Packet A5 7E 10 03 01 02 03 → writes (126,16), (127,16), (0,17). Then packet A5 7F 7F 02 AA BB → writes (127,127), (0,0).
- Packet with N = 0 plus 256 bytes, with `wr_ready` toggling pseudo-randomly → exactly 256 writes in order; no byte lost or duplicated; `in_ready` low only while `wr_valid & !wr_ready`.
- Assert `rst_n` = 0 for one cycle after the second pixel of a 4-pixel packet → `wr_valid` = 0 and `busy` = 0 after that edge. Following bytes are treated as IDLE.
- With `FB_LOADER_CHECKSUM_EN`: A5 01 02 01 33 + checksum 0x31 → `err` = 0. Same packet with checksum 0x00 → `err` = 1, still high after `pkt_done`; it clears on the next A5.
